// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-lite response codes and register index decode.
// Used by the CSR endpoint and its write-path submodule.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  function automatic int unsigned reg_index(
    input logic [63:0] addr,
    input int unsigned l,
    input int unsigned n
  );
    logic [63:0] m;
    m = (64'd1 << l) - 64'd1;
    return 32'((addr & m) >> $clog2(n));
  endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4-lite subset bundle with master/slave modports.
// IDs ride along so the endpoint can echo them.
interface axi4_if #(
  parameter int A = 32,
  parameter int N = 4,
  parameter int I = 4
);
  logic [I-1:0]   awid;
  logic [A-1:0]   awaddr;
  logic           awvalid;
  logic           awready;
  logic [8*N-1:0] wdata;
  logic [N-1:0]   wstrb;
  logic           wvalid;
  logic           wready;
  logic [I-1:0]   bid;
  logic [1:0]     bresp;
  logic           buser;
  logic           bvalid;
  logic           bready;
  logic [I-1:0]   arid;
  logic [A-1:0]   araddr;
  logic           arvalid;
  logic           arready;
  logic [I-1:0]   rid;
  logic [8*N-1:0] rdata;
  logic [1:0]     rresp;
  logic           rlast;
  logic           ruser;
  logic           rvalid;
  logic           rready;

  modport slave (
    input  awid, awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, arid, araddr, arvalid, rready,
    output awready, wready, bid, bresp, buser, bvalid,
    output arready, rid, rdata, rresp, rlast, ruser, rvalid
  );

  modport master (
    output awid, awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, arid, araddr, arvalid, rready,
    input  awready, wready, bid, bresp, buser, bvalid,
    input  arready, rid, rdata, rresp, rlast, ruser, rvalid
  );
endinterface

// File: rtl/axi4_lite_csr_wr.sv
// Write path of the CSR bank: AW/W pairing FSM, byte-strobe
// commit into the register array and the per-register write pulse.
module axi4_lite_csr_wr
  import axi4_lite_pkg::*;
#(
  parameter int A = 32,
  parameter int N = 4,
  parameter int I = 4,
  parameter int L = 8,
  parameter int R = 4,
  parameter logic [R-1:0] RO = '0
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   awvalid,
  input  logic [A-1:0]           awaddr,
  input  logic [I-1:0]           awid,
  output logic                   awready,
  input  logic                   wvalid,
  input  logic [8*N-1:0]         wdata,
  input  logic [N-1:0]           wstrb,
  output logic                   wready,
  output logic                   bvalid,
  input  logic                   bready,
  output logic [I-1:0]           bid,
  output logic [1:0]             bresp,
  output logic [R-1:0][8*N-1:0]  reg_q,
  output logic [R-1:0]           wr_pulse
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    IDLE, HAVE_AW, HAVE_W, RESP
  } wr_state_t;

  wr_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic err_q, err_d;
  logic [I-1:0] awid_q, awid_d;
  logic [8*N-1:0] wdata_q, wdata_d;
  logic [N-1:0] wstrb_q, wstrb_d;
  logic bvalid_q, bvalid_d;
  logic [I-1:0] bid_q, bid_d;
  resp_t bresp_q, bresp_d;
  logic [R-1:0][8*N-1:0] regs_q, regs_d;
  logic [R-1:0] pulse_q, pulse_d;

  function automatic logic idx_err(input int unsigned i);
    if (i >= R) return 1'b1;
    return RO[IW'(i)];
  endfunction

  int unsigned aw_i;
  logic aw_ok, w_ok, commit;
  logic [IW-1:0] cur_idx;
  logic cur_err;
  logic [I-1:0] cur_id;
  logic [8*N-1:0] cur_data;
  logic [N-1:0] cur_strb;

  assign awready = (state_q == IDLE) || (state_q == HAVE_W);
  assign wready  = (state_q == IDLE) || (state_q == HAVE_AW);
  assign aw_ok   = awvalid && awready;
  assign w_ok    = wvalid && wready;

  always_comb begin
    aw_i     = reg_index(64'(awaddr), L, N);
    cur_idx  = (state_q == HAVE_AW) ? idx_q : IW'(aw_i);
    cur_err  = (state_q == HAVE_AW) ? err_q : idx_err(aw_i);
    cur_id   = (state_q == HAVE_AW) ? awid_q : awid;
    cur_data = (state_q == HAVE_W) ? wdata_q : wdata;
    cur_strb = (state_q == HAVE_W) ? wstrb_q : wstrb;
    commit   = (state_q == IDLE && aw_ok && w_ok)
            || (state_q == HAVE_AW && w_ok)
            || (state_q == HAVE_W && aw_ok);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    err_d    = err_q;
    awid_d   = awid_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bvalid_d = bvalid_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    regs_d   = regs_q;
    pulse_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (aw_ok && !w_ok) begin
          state_d = HAVE_AW;
          idx_d   = IW'(aw_i);
          err_d   = idx_err(aw_i);
          awid_d  = awid;
        end else if (w_ok && !aw_ok) begin
          state_d = HAVE_W;
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
      end
      HAVE_AW, HAVE_W: ;
      RESP: begin
        if (bready) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end
    endcase
    // Pairing completes: commit and raise the response together
    if (commit) begin
      state_d  = RESP;
      bvalid_d = 1'b1;
      bid_d    = cur_id;
      bresp_d  = cur_err ? SLVERR : OKAY;
      if (!cur_err) begin
        pulse_d[cur_idx] = 1'b1;
        for (int b = 0; b < N; b++) begin
          if (cur_strb[b]) regs_d[cur_idx][8*b+:8] = cur_data[8*b+:8];
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      err_q    <= 1'b0;
      awid_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= OKAY;
      regs_q   <= '0;
      pulse_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      awid_q   <= awid_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bvalid_q <= bvalid_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      regs_q   <= regs_d;
      pulse_q  <= pulse_d;
    end
  end

  assign bvalid   = bvalid_q;
  assign bid      = bid_q;
  assign bresp    = bresp_q;
  assign reg_q    = regs_q;
  assign wr_pulse = pulse_q;

endmodule

// File: rtl/axi4_lite_csr.sv
// AXI4-lite control/status register bank behind one fanout leg.
// Read path lives here; the write path is in axi4_lite_csr_wr.
module axi4_lite_csr
  import axi4_lite_pkg::*;
#(
  parameter int A = 32,
  parameter int N = 4,
  parameter int I = 4,
  parameter int L = 8,
  parameter int R = 4,
  parameter logic [R-1:0] RO = '0
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axi4_if.slave                 axi4_s,
  output logic [R-1:0][8*N-1:0] reg_q,
  output logic [R-1:0]          wr_pulse,
  input  logic [R-1:0][8*N-1:0] status_d
);

  localparam int IW = (R > 1) ? $clog2(R) : 1;

  logic [1:0] bresp_w;

  axi4_lite_csr_wr #(
    .A(A), .N(N), .I(I), .L(L), .R(R), .RO(RO)
  ) u_wr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .awvalid (axi4_s.awvalid),
    .awaddr  (axi4_s.awaddr),
    .awid    (axi4_s.awid),
    .awready (axi4_s.awready),
    .wvalid  (axi4_s.wvalid),
    .wdata   (axi4_s.wdata),
    .wstrb   (axi4_s.wstrb),
    .wready  (axi4_s.wready),
    .bvalid  (axi4_s.bvalid),
    .bready  (axi4_s.bready),
    .bid     (axi4_s.bid),
    .bresp   (bresp_w),
    .reg_q   (reg_q),
    .wr_pulse(wr_pulse)
  );

  assign axi4_s.bresp = bresp_w;
  assign axi4_s.buser = 1'b0;

  logic rvalid_q, rvalid_d;
  logic [I-1:0] rid_q, rid_d;
  logic [8*N-1:0] rdata_q, rdata_d;
  resp_t rresp_q, rresp_d;
  int unsigned ridx;
  logic [IW-1:0] ri;

  always_comb begin
    rvalid_d = rvalid_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    ridx     = reg_index(64'(axi4_s.araddr), L, N);
    ri       = IW'(ridx);
    if (axi4_s.arvalid && !rvalid_q) begin
      rvalid_d = 1'b1;
      rid_d    = axi4_s.arid;
      if (ridx >= R) begin
        rdata_d = '0;
        rresp_d = SLVERR;
      end else begin
        rresp_d = OKAY;
        // Status is sampled live; a same-edge write is not yet visible
        rdata_d = RO[ri] ? status_d[ri] : reg_q[ri];
      end
    end else if (rvalid_q && axi4_s.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign axi4_s.arready = !rvalid_q;
  assign axi4_s.rvalid  = rvalid_q;
  assign axi4_s.rid     = rid_q;
  assign axi4_s.rdata   = rdata_q;
  assign axi4_s.rresp   = rresp_q;
  assign axi4_s.rlast   = 1'b1;
  assign axi4_s.ruser   = 1'b0;

endmodule

// File: tb/tb_axi4_lite_csr.sv
// Scoreboard bench for axi4_lite_csr: expected B/R responses are
// queued at issue time and popped on each response handshake.
module tb_axi4_lite_csr;

  localparam int A = 32;
  localparam int N = 4;
  localparam int I = 4;
  localparam int L = 8;
  localparam int R = 4;
  localparam logic [R-1:0] RO = 4'b1000;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  axi4_if #(.A(A), .N(N), .I(I)) bus ();

  logic [R-1:0][31:0] reg_q;
  logic [R-1:0][31:0] status_d;
  logic [R-1:0] wr_pulse;

  axi4_lite_csr #(
    .A(A), .N(N), .I(I), .L(L), .R(R), .RO(RO)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axi4_s  (bus.slave),
    .reg_q   (reg_q),
    .wr_pulse(wr_pulse),
    .status_d(status_d)
  );

  typedef struct {
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;

  exp_t bq[$];
  exp_t rq[$];
  logic [31:0] model [R];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge aclk) begin : b_mon
    exp_t e;
    if (aresetn && bus.bvalid && bus.bready) begin
      if (bq.size() == 0) check("b_unexpected", 64'd1, 64'd0);
      else begin
        e = bq.pop_front();
        check("bid", 64'(bus.bid), 64'(e.id));
        check("bresp", 64'(bus.bresp), 64'(e.resp));
      end
    end
  end

  always @(negedge aclk) begin : r_mon
    exp_t e;
    if (aresetn && bus.rvalid && bus.rready) begin
      if (rq.size() == 0) check("r_unexpected", 64'd1, 64'd0);
      else begin
        e = rq.pop_front();
        check("rid", 64'(bus.rid), 64'(e.id));
        check("rresp", 64'(bus.rresp), 64'(e.resp));
        check("rdata", 64'(bus.rdata), 64'(e.data));
        check("rlast", 64'(bus.rlast), 64'd1);
      end
    end
  end

  task automatic expect_wr(logic [31:0] addr, logic [3:0] id,
                           logic [31:0] data, logic [3:0] strb);
    int i;
    logic err;
    exp_t e;
    i = int'((addr & 32'hFF) >> 2);
    err = (i >= R) ? 1'b1 : RO[i];
    e.id = id;
    e.resp = err ? 2'd2 : 2'd0;
    e.data = '0;
    bq.push_back(e);
    if (!err)
      for (int b = 0; b < N; b++)
        if (strb[b]) model[i][8*b+:8] = data[8*b+:8];
  endtask

  task automatic expect_rd(logic [31:0] addr, logic [3:0] id);
    int i;
    exp_t e;
    i = int'((addr & 32'hFF) >> 2);
    e.id = id;
    if (i >= R) begin
      e.resp = 2'd2;
      e.data = '0;
    end else begin
      e.resp = 2'd0;
      e.data = RO[i] ? status_d[i] : model[i];
    end
    rq.push_back(e);
  endtask

  task automatic do_aw(logic [31:0] addr, logic [3:0] id);
    int k;
    bus.awaddr = addr;
    bus.awid = id;
    bus.awvalid = 1'b1;
    k = 0;
    @(negedge aclk);
    while (!bus.awready && k < 50) begin
      @(negedge aclk);
      k++;
    end
    check("aw_ready", 64'(bus.awready), 64'd1);
    @(posedge aclk);
    #1 bus.awvalid = 1'b0;
  endtask

  task automatic do_w(logic [31:0] data, logic [3:0] strb);
    int k;
    bus.wdata = data;
    bus.wstrb = strb;
    bus.wvalid = 1'b1;
    k = 0;
    @(negedge aclk);
    while (!bus.wready && k < 50) begin
      @(negedge aclk);
      k++;
    end
    check("w_ready", 64'(bus.wready), 64'd1);
    @(posedge aclk);
    #1 bus.wvalid = 1'b0;
  endtask

  task automatic do_ar(logic [31:0] addr, logic [3:0] id);
    int k;
    bus.araddr = addr;
    bus.arid = id;
    bus.arvalid = 1'b1;
    k = 0;
    @(negedge aclk);
    while (!bus.arready && k < 50) begin
      @(negedge aclk);
      k++;
    end
    check("ar_ready", 64'(bus.arready), 64'd1);
    @(posedge aclk);
    #1 bus.arvalid = 1'b0;
  endtask

  task automatic write(logic [31:0] addr, logic [3:0] id,
                       logic [31:0] data, logic [3:0] strb);
    expect_wr(addr, id, data, strb);
    fork
      do_aw(addr, id);
      do_w(data, strb);
    join
  endtask

  task automatic read(logic [31:0] addr, logic [3:0] id);
    expect_rd(addr, id);
    do_ar(addr, id);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((bq.size() != 0 || rq.size() != 0) && k < 100) begin
      @(posedge aclk);
      k++;
    end
    check("drain", 64'(bq.size() + rq.size()), 64'd0);
    @(posedge aclk);
    #1;
  endtask

  task automatic check_regs();
    for (int r = 0; r < R; r++)
      check($sformatf("reg_q[%0d]", r), 64'(reg_q[r]), 64'(model[r]));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.awid = '0; bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.arid = '0; bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    status_d[0] = 32'hDEAD0000;
    status_d[1] = 32'hDEAD0001;
    status_d[2] = 32'hDEAD0002;
    status_d[3] = 32'h12345678;
    for (int r = 0; r < R; r++) model[r] = '0;

    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", 64'(bus.awready), 64'd1);
    check("rst_wready", 64'(bus.wready), 64'd1);
    check("rst_arready", 64'(bus.arready), 64'd1);
    check("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_bresp", 64'(bus.bresp), 64'd0);
    check("rst_rresp", 64'(bus.rresp), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_regq", 64'(|reg_q), 64'd0);
    check("rst_pulse", 64'(wr_pulse), 64'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    // same-cycle AW+W
    write(32'h04, 4'd3, 32'hA5A5A5A5, 4'hF);
    check("t1_bvalid", 64'(bus.bvalid), 64'd1);
    check("t1_pulse", 64'(wr_pulse), 64'b0010);
    @(posedge aclk);
    #1;
    check("t1_pulse_off", 64'(wr_pulse), 64'd0);
    check("t1_awready", 64'(bus.awready), 64'd1);
    check("t1_wready", 64'(bus.wready), 64'd1);
    drain();
    check_regs();

    // W first, AW a few cycles later, single byte strobe
    expect_wr(32'h08, 4'd2, 32'h0000BB00, 4'h2);
    do_w(32'h0000BB00, 4'h2);
    repeat (3) begin
      @(negedge aclk);
      check("t2_wready_low", 64'(bus.wready), 64'd0);
      check("t2_awready", 64'(bus.awready), 64'd1);
    end
    @(posedge aclk);
    #1;
    do_aw(32'h08, 4'd2);
    check("t2_wready_resp", 64'(bus.wready), 64'd0);
    check("t2_pulse", 64'(wr_pulse), 64'b0100);
    @(posedge aclk);
    #1;
    check("t2_wready_back", 64'(bus.wready), 64'd1);
    drain();
    check_regs();

    // RO register: read status, write rejected
    read(32'h0C, 4'd1);
    check("t3_rvalid", 64'(bus.rvalid), 64'd1);
    drain();
    write(32'h0C, 4'd4, 32'hFFFFFFFF, 4'hF);
    check("t3_bvalid", 64'(bus.bvalid), 64'd1);
    check("t3_nopulse", 64'(wr_pulse), 64'd0);
    drain();
    check_regs();

    // out-of-range index
    read(32'h40, 4'd6);
    drain();
    write(32'h40, 4'd6, 32'h12121212, 4'hF);
    check("t4_nopulse", 64'(wr_pulse), 64'd0);
    drain();
    check_regs();

    // back-pressure on both response channels
    bus.bready = 1'b0;
    bus.rready = 1'b0;
    write(32'h08, 4'd7, 32'h11223344, 4'hF);
    read(32'h04, 4'd5);
    repeat (10) begin
      @(negedge aclk);
      check("t5_bvalid", 64'(bus.bvalid), 64'd1);
      check("t5_bid", 64'(bus.bid), 64'd7);
      check("t5_bresp", 64'(bus.bresp), 64'd0);
      check("t5_rvalid", 64'(bus.rvalid), 64'd1);
      check("t5_rid", 64'(bus.rid), 64'd5);
      check("t5_rdata", 64'(bus.rdata), 64'hA5A5A5A5);
      check("t5_awready", 64'(bus.awready), 64'd0);
      check("t5_wready", 64'(bus.wready), 64'd0);
      check("t5_arready", 64'(bus.arready), 64'd0);
    end
    @(posedge aclk);
    #1;
    bus.bready = 1'b1;
    bus.rready = 1'b1;
    @(posedge aclk);
    #1;
    check("t5_awready_back", 64'(bus.awready), 64'd1);
    check("t5_arready_back", 64'(bus.arready), 64'd1);
    drain();
    check_regs();

    // read and write of reg 0 in the same cycle
    write(32'h00, 4'd1, 32'h1, 4'hF);
    drain();
    expect_rd(32'h00, 4'd2);
    expect_wr(32'h00, 4'd3, 32'h2, 4'hF);
    fork
      do_ar(32'h00, 4'd2);
      do_aw(32'h00, 4'd3);
      do_w(32'h2, 4'hF);
    join
    drain();
    read(32'h00, 4'd4);
    drain();
    check_regs();

    // reset while B is pending
    bus.bready = 1'b0;
    write(32'h04, 4'd8, 32'h77, 4'h1);
    check("t7_bvalid", 64'(bus.bvalid), 64'd1);
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("t7_bvalid_rst", 64'(bus.bvalid), 64'd0);
    check("t7_regq_rst", 64'(|reg_q), 64'd0);
    check("t7_awready_rst", 64'(bus.awready), 64'd1);
    bq.delete();
    for (int r = 0; r < R; r++) model[r] = '0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    bus.bready = 1'b1;
    @(posedge aclk);
    #1;
    write(32'h04, 4'd9, 32'h5, 4'hF);
    drain();
    check_regs();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
